// File: rtl/pipe_pkg.sv
// Shared types and field-width constants for the pipeline stage registers.
// Optional perf counters in pipe_stage_buf are enabled by the PIPE_STAGE_PERF_EN macro.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;

   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned WB_W      = 2;
   localparam int unsigned CTRL_DEF_W = REG_IDX_W + WB_W;

   // All-zero control is an architectural no-op.
   localparam logic [CTRL_DEF_W-1:0] CTRL_NOP = '0;

   typedef struct packed {
      logic [REG_IDX_W-1:0] write_reg;
      logic [WB_W-1:0]      wb;
   } pipe_ctrl_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for stage stall/bubble statistics.
module pipe_sat_counter
   import pipe_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             pc_rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   // Hold at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge pc_rst) begin
      if (!pc_rst) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with 2-entry skid buffer, valid/ready handshake and flush.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/bubble_cnt counters.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned CTRL_W   = 7,
   parameter int unsigned CLR_DATA = 0,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clk,
   input  logic              pc_rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   pipe_state_t       state;
   pipe_state_t       state_nxt;
   logic [DATA_W-1:0] head_data;
   logic [DATA_W-1:0] head_data_nxt;
   logic [CTRL_W-1:0] head_ctrl;
   logic [CTRL_W-1:0] head_ctrl_nxt;
   logic [DATA_W-1:0] skid_data;
   logic [DATA_W-1:0] skid_data_nxt;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [CTRL_W-1:0] skid_ctrl_nxt;
   logic              accept;
   logic              drain;

   // Handshake flags depend only on registered state, so no in_* -> out_* path exists.
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign out_data  = head_data;
   assign out_ctrl  = head_ctrl;

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   always_ff @(posedge clk or negedge pc_rst) begin
      if (!pc_rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (accept) state_nxt = HALF;
            HALF: begin
               if (accept && !drain)      state_nxt = FULL;
               else if (!accept && drain) state_nxt = EMPTY;
            end
            FULL:    if (drain) state_nxt = HALF;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // Entry movement; head ctrl is cleared whenever the stage goes empty so a bubble is a no-op.
   always_comb begin
      head_data_nxt = head_data;
      head_ctrl_nxt = head_ctrl;
      skid_data_nxt = skid_data;
      skid_ctrl_nxt = skid_ctrl;
      if (flush) begin
         head_ctrl_nxt = CTRL_W'(CTRL_NOP);
         skid_ctrl_nxt = CTRL_W'(CTRL_NOP);
         if (CLR_DATA != 0) begin
            head_data_nxt = '0;
            skid_data_nxt = '0;
         end
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  head_data_nxt = in_data;
                  head_ctrl_nxt = in_ctrl;
               end
            end
            HALF: begin
               if (accept && drain) begin
                  head_data_nxt = in_data;
                  head_ctrl_nxt = in_ctrl;
               end else if (accept) begin
                  skid_data_nxt = in_data;
                  skid_ctrl_nxt = in_ctrl;
               end else if (drain) begin
                  head_ctrl_nxt = CTRL_W'(CTRL_NOP);
               end
            end
            FULL: begin
               if (drain) begin
                  head_data_nxt = skid_data;
                  head_ctrl_nxt = skid_ctrl;
               end
            end
            default: begin
               head_ctrl_nxt = CTRL_W'(CTRL_NOP);
               skid_ctrl_nxt = CTRL_W'(CTRL_NOP);
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge pc_rst) begin
      if (!pc_rst) begin
         head_data <= '0;
         head_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
      end else begin
         head_data <= head_data_nxt;
         head_ctrl <= head_ctrl_nxt;
         skid_data <= skid_data_nxt;
         skid_ctrl <= skid_ctrl_nxt;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk    (clk),
      .pc_rst (pc_rst),
      .inc    (out_valid & ~out_ready),
      .cnt    (stall_cnt)
   );

   pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk    (clk),
      .pc_rst (pc_rst),
      .inc    (~out_valid),
      .cnt    (bubble_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf against a queue-based reference model.
// Counter checks are compiled in when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_buf;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned CTRL_W = 7;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              pc_rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  bubble_cnt;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
   } ent_t;

   ent_t q[$];
   int   m_stall  = 0;
   int   m_bubble = 0;

   pipe_stage_buf #(
      .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLR_DATA(0), .CNT_W(CNT_W)
   ) dut (
      .clk       (clk),
      .pc_rst    (pc_rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every visible output against the model's queue contents.
   task automatic check_model(input string tag);
      logic [CTRL_W-1:0] ec;
      ec = (q.size() > 0) ? q[0].c : '0;
      check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
      check({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
      check({tag, ".out_ctrl"}, 64'(out_ctrl), 64'(ec));
      if (q.size() > 0) check({tag, ".out_data"}, out_data, q[0].d);
`ifdef PIPE_STAGE_PERF_EN
      check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
      check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(m_bubble));
`endif
   endtask

   // One clock cycle: drive inputs, advance model at the edge, check 1 time unit later.
   task automatic step(input string tag, input logic f, input logic iv,
                       input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ord);
      bit mv;
      bit acc;
      flush     = f;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ord;
      mv  = (q.size() > 0);
      acc = iv && (q.size() < 2);
      @(posedge clk);
      if (mv && !ord && m_stall < int'(CMAX)) m_stall++;
      if (!mv && m_bubble < int'(CMAX)) m_bubble++;
      if (f) begin
         q.delete();
      end else begin
         if (mv && ord) void'(q.pop_front());
         if (acc) q.push_back('{c: c, d: d});
      end
      #1;
      check_model(tag);
   endtask

   initial begin
      int sv_stall;
      int sv_bubble;
      pc_rst    = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_ctrl   = '0;
      out_ready = 1'b0;

      // Reset state
      #12;
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.out_ctrl", 64'(out_ctrl), 64'd0);
      check("rst.out_data", out_data, 64'd0);
      check("rst.in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      pc_rst = 1'b1;

      // Streaming back-to-back; HALF accept&drain replaces head
      step("stream0", 1'b0, 1'b1, 64'h1001, 7'h41, 1'b1);
      check("stream0.ctrl", 64'(out_ctrl), 64'h41);
      step("stream1", 1'b0, 1'b1, 64'h1002, 7'h42, 1'b1);
      check("stream1.ctrl", 64'(out_ctrl), 64'h42);
      step("stream2", 1'b0, 1'b1, 64'h1003, 7'h43, 1'b1);
      check("stream2.ctrl", 64'(out_ctrl), 64'h43);
      check("stream2.in_ready", 64'(in_ready), 64'd1);
      step("stream3", 1'b0, 1'b0, 64'h0, 7'h0, 1'b1);
      check("stream3.empty", 64'(out_valid), 64'd0);

      // Backpressure: two accepts fill head and skid
      step("bp0", 1'b0, 1'b1, 64'h2001, 7'h11, 1'b0);
      step("bp1", 1'b0, 1'b1, 64'h2002, 7'h12, 1'b0);
      check("bp1.full", 64'(in_ready), 64'd0);
      step("bp2", 1'b0, 1'b1, 64'h2003, 7'h13, 1'b0);
      step("bp3", 1'b0, 1'b0, 64'h0, 7'h0, 1'b1);
      check("bp3.second", 64'(out_ctrl), 64'h12);
      step("bp4", 1'b0, 1'b0, 64'h0, 7'h0, 1'b1);
      check("bp4.empty", 64'(out_valid), 64'd0);

      // Flush while FULL with a new entry offered
      step("fl0", 1'b0, 1'b1, 64'h3001, 7'h21, 1'b0);
      step("fl1", 1'b0, 1'b1, 64'h3002, 7'h22, 1'b0);
      step("fl2", 1'b1, 1'b1, 64'hAB, 7'h2B, 1'b0);
      check("fl2.valid", 64'(out_valid), 64'd0);
      check("fl2.ctrl", 64'(out_ctrl), 64'd0);
      check("fl2.in_ready", 64'(in_ready), 64'd1);
      step("fl3", 1'b0, 1'b0, 64'h0, 7'h0, 1'b1);
      step("fl4", 1'b0, 1'b1, 64'h3003, 7'h23, 1'b1);

`ifdef PIPE_STAGE_PERF_EN
      // Stall counter saturates; flush leaves counts alone
      step("pf0", 1'b0, 1'b1, 64'h4001, 7'h31, 1'b0);
      for (int i = 0; i < 20; i++) step("pf_hold", 1'b0, 1'b0, 64'h0, 7'h0, 1'b0);
      check("pf.stall_sat", 64'(stall_cnt), 64'(CMAX));
      sv_stall  = int'(stall_cnt);
      sv_bubble = int'(bubble_cnt);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("pf.flush_stall", 64'(stall_cnt), 64'(CMAX));
      check("pf.flush_bubble", 64'(bubble_cnt), 64'(sv_bubble));
      q.delete();
      if (sv_stall != int'(CMAX)) check("pf.saved", 64'(sv_stall), 64'(CMAX));
`endif

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         step("rnd", ($urandom_range(0, 15) == 0), 1'($urandom), {$urandom, $urandom},
              7'($urandom), ($urandom_range(0, 3) != 0));
      end

      // Async reset mid-stream while FULL
      step("ar0", 1'b0, 1'b1, 64'h5001, 7'h51, 1'b0);
      step("ar1", 1'b0, 1'b1, 64'h5002, 7'h52, 1'b0);
      step("ar2", 1'b0, 1'b1, 64'h5003, 7'h53, 1'b0);
      #2;
      pc_rst = 1'b0;
      #1;
      q.delete();
      m_stall  = 0;
      m_bubble = 0;
      check("ar.out_valid", 64'(out_valid), 64'd0);
      check("ar.out_ctrl", 64'(out_ctrl), 64'd0);
      check("ar.in_ready", 64'(in_ready), 64'd1);
      check_model("ar.model");
      @(posedge clk);
      #1;
      check("ar.held_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      in_valid = 1'b0;
      pc_rst   = 1'b1;
      step("ar3", 1'b0, 1'b1, 64'h6001, 7'h61, 1'b1);
      check("ar3.first", 64'(out_ctrl), 64'h61);
      step("ar4", 1'b0, 1'b0, 64'h0, 7'h0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
